// File: rtl/note_tone_bank.sv
// Twelve free-running 50% duty square-wave note generators plus a constant-low rest line.
// Each channel toggles its output every HALF_n enabled clocks; en low or rst clears all phases.
module note_tone_bank #(
    parameter int CW      = 18,
    parameter int HALF_1  = 113636,
    parameter int HALF_2  = 101239,
    parameter int HALF_3  = 191110,
    parameter int HALF_4  = 170264,
    parameter int HALF_5  = 151685,
    parameter int HALF_6  = 143172,
    parameter int HALF_7  = 127551,
    parameter int HALF_8  = 107259,
    parameter int HALF_9  = 95556,
    parameter int HALF_10 = 90192,
    parameter int HALF_11 = 85131,
    parameter int HALF_12 = 120394
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [12:0] tone
);

    function automatic int half_of(input int n);
        case (n)
            1:       half_of = HALF_1;
            2:       half_of = HALF_2;
            3:       half_of = HALF_3;
            4:       half_of = HALF_4;
            5:       half_of = HALF_5;
            6:       half_of = HALF_6;
            7:       half_of = HALF_7;
            8:       half_of = HALF_8;
            9:       half_of = HALF_9;
            10:      half_of = HALF_10;
            11:      half_of = HALF_11;
            default: half_of = HALF_12;
        endcase
    endfunction

    logic [12:1] tone_q;

    assign tone = {tone_q, 1'b0};

    for (genvar n = 1; n <= 12; n++) begin : g_ch
        localparam int HALF = half_of(n);
        // Wrap point; a zero or oversized HALF is rejected below before this value matters.
        localparam logic [CW-1:0] LAST = CW'(HALF - 1);

        if (HALF < 1) begin : g_bad_zero
            $error("note_tone_bank: HALF_%0d must be at least 1", n);
        end
        if (longint'(HALF) >= (longint'(1) << CW)) begin : g_bad_wide
            $error("note_tone_bank: HALF_%0d does not fit in CW=%0d bits", n, CW);
        end

        logic [CW-1:0] cnt;
        logic          tq;

        always_ff @(posedge clk) begin
            if (rst || !en) begin
                cnt <= '0;
                tq  <= 1'b0;
            end else if (cnt == LAST) begin
                cnt <= '0;
                tq  <= ~tq;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign tone_q[n] = tq;
    end

endmodule
